uart_sys_cfg: RTL and testbench
===============================

// Module: uart_sys_cfg
// PURPOSE
//  Runtime-configurable full-duplex UART with TX/RX FIFOs; successor to the fixed-format UART system.
//  Adds a programmable baud divisor, 1/2 stop bits, RX start-glitch rejection, an RX input synchroniser,
//  sticky frame/overrun errors and FIFO fill levels. Sits between the register/CPU side (wr/rd strobes)
//  and the board serial pins.
// PARAMETERS
//  DBIT        8   data bits per frame (5..9), sent LSB first
//  OVERSAMPLE  16  s_ticks per bit period (even, >=4)
//  DIV_W       11  width of baud_div
//  FIFO_DEPTH  16  entries per FIFO (power of 2, >=2)
// PORTS
//  clk          in   1                 system clock
//  rst_n        in   1                 asynchronous active-low reset
//  baud_div     in   DIV_W             baud generator terminal count
//  stop_2       in   1                 1 = two stop bits, 0 = one stop bit
//  wr_uart      in   1                 push w_data into TX FIFO
//  w_data       in   DBIT              TX write data
//  rd_uart      in   1                 pop RX FIFO into r_data
//  err_clr      in   1                 clear sticky error flags
//  rx           in   1                 serial input (asynchronous)
//  tx           out  1                 serial output
//  r_data       out  DBIT              registered RX read data
//  tx_full      out  1                 TX FIFO full
//  rx_empty     out  1                 RX FIFO empty
//  tx_level     out  $clog2(FIFO_DEPTH)+1  TX FIFO occupancy
//  rx_level     out  $clog2(FIFO_DEPTH)+1  RX FIFO occupancy
//  frame_err    out  1                 sticky: stop bit sampled 0
//  overrun_err  out  1                 sticky: received word dropped, RX FIFO full
// BEHAVIOUR
//  Reset (async): tx=1, r_data=0, tx_full=0, rx_empty=1, levels=0, errors=0, both FSMs IDLE, FIFOs emptied.
//   Asserting reset mid-frame aborts the frame and drops tx to 1 immediately.
//  Baud: counter 0..baud_div; s_tick high one clk when count==baud_div, then wraps to 0. baud_div=0 gives s_tick every clk.
//  Config shadow: baud_div/stop_2 (and parity_odd) are latched only when both TX and RX FSMs are IDLE.
//   They are never changed mid-frame.
//  States (shared enum): IDLE, START, DATA, PARITY, STOP. Each bit lasts OVERSAMPLE s_ticks.
//   STOP lasts OVERSAMPLE or 2*OVERSAMPLE s_ticks.
//  TX: IDLE and FIFO non-empty -> pop word into shift reg and go to START (tx=0).
//   DATA shifts out DBIT bits; [PARITY]; STOP (tx=1); then IDLE for >=1 clk.
//   Back-to-back frames continue while the FIFO is non-empty.
//  RX: rx passes a 2-FF synchroniser (reset value 1).
//   IDLE sees 0 -> START; at s_tick count OVERSAMPLE/2-1, sync rx=0 -> DATA, else IDLE (glitch reject, nothing pushed).
//   Each DATA bit is sampled at its midpoint.
//   STOP is sampled at the midpoint of its first stop bit; if 0, set frame_err and still push the word.
//  RX push: if the RX FIFO is full, drop the word and set overrun_err; FIFO contents are unchanged.
//  wr_uart while tx_full: ignored. rd_uart while rx_empty: ignored, r_data holds.
//   A valid rd_uart updates r_data on the next clk edge.
//  Simultaneous push/pop is allowed at any level. Full/empty gating uses the current-cycle flags.
//   Level is unchanged on simultaneous push and pop.
//  Pointers are $clog2(FIFO_DEPTH)+1 bits and wrap naturally.
//   Full when addresses are equal and MSBs differ; empty when the pointers are equal.
//  err_clr clears sticky flags next clk. A new error in the same cycle wins (flag stays set).
// CONFIGURATION
//  `UART_PARITY_EN defined: adds input parity_odd (1 = odd, 0 = even) and output sticky parity_err.
//   PARITY state is inserted after DATA in both TX and RX. TX sends the parity bit.
//   RX checks the parity bit at its midpoint and sets parity_err on mismatch; the word is still pushed.
//   err_clr also clears parity_err.
//  Not defined: no PARITY state, no parity ports; the frame is start + DBIT + stop(s).
// STRUCTURE
//  uart_cfg_pkg: state enum (IDLE, START, DATA, PARITY, STOP), default-parameter localparams, level-width function.
//  Sub-module uart_cfg_fifo (sync FIFO: push/pop/full/empty/level, registered pop data), instantiated twice.
//   BRG, TX FSM and RX FSM stay inline.
// TESTING (DBIT=8, OVERSAMPLE=16, baud_div=3 -> 64 clk/bit)
//  Write 0xA5, stop_2=0 -> tx low 64 clk, then bits 1,0,1,0,0,1,0,1 LSB first, then high 64 clk; tx_level 1->0.
//  Drive rx frame 0x3C -> rx_empty falls ~1 clk after the stop midpoint (+2 sync clks);
//   rd_uart -> r_data=0x3C next clk, rx_empty=1.
//  17 writes with 0 drained (baud_div max) -> tx_full=1 after the 16th write; the 17th is ignored, tx_level=16.
//  17 rx frames without reading -> overrun_err=1 and rx_level=16; err_clr -> overrun_err=0; r_data = first word.
//  rx low pulse of 20 clk -> no push, no error; rx stop bit held 0 -> frame_err=1 and the word is pushed.
//  rst_n low mid-DATA -> tx=1, levels 0; with UART_PARITY_EN, odd parity, send 0x01 -> parity bit 0,
//   corrupted parity -> parity_err=1.

Source files
------------

// File: rtl/uart_cfg_pkg.sv
// uart_cfg_pkg: shared FSM state type, default parameters and FIFO level width helper.
package uart_cfg_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam int DBIT_DEF = 8;
  localparam int OVERSAMPLE_DEF = 16;
  localparam int DIV_W_DEF = 11;
  localparam int FIFO_DEPTH_DEF = 16;
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/uart_cfg_if.sv
// uart_cfg_if: CPU-side strobes, configuration, status and serial pins of the configurable UART.
// UART_PARITY_EN adds parity_odd / parity_err.
interface uart_cfg_if
  import uart_cfg_pkg::*;
#(
  parameter int DBIT = DBIT_DEF,
  parameter int DIV_W = DIV_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
);
  logic [DIV_W-1:0] baud_div;
  logic stop_2, wr_uart, rd_uart, err_clr, rx, tx;
  logic [DBIT-1:0] w_data, r_data;
  logic tx_full, rx_empty, frame_err, overrun_err;
  logic [lvl_w(FIFO_DEPTH)-1:0] tx_level, rx_level;
`ifdef UART_PARITY_EN
  logic parity_odd, parity_err;
`endif
  modport master (
    output baud_div, stop_2, wr_uart, w_data, rd_uart, err_clr, rx,
`ifdef UART_PARITY_EN
    output parity_odd, input parity_err,
`endif
    input tx, r_data, tx_full, rx_empty, tx_level, rx_level, frame_err, overrun_err
  );
  modport slave (
    input baud_div, stop_2, wr_uart, w_data, rd_uart, err_clr, rx,
`ifdef UART_PARITY_EN
    input parity_odd, output parity_err,
`endif
    output tx, r_data, tx_full, rx_empty, tx_level, rx_level, frame_err, overrun_err
  );
endinterface

// File: rtl/uart_cfg_fifo.sv
// uart_cfg_fifo: synchronous FIFO with occupancy level and registered pop data.
module uart_cfg_fifo
  import uart_cfg_pkg::*;
#(
  parameter int W = DBIT_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  logic pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic full_o,
  output logic empty_o,
  output logic [lvl_w(DEPTH)-1:0] level_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;
  logic [AW:0] wp_q, rp_q;
  logic do_push, do_pop;
  assign full_o = (wp_q[AW-1:0] == rp_q[AW-1:0]) && (wp_q[AW] != rp_q[AW]);
  assign empty_o = wp_q == rp_q;
  assign do_push = push_i && !full_o;
  assign do_pop = pop_i && !empty_o;
  assign level_o = wp_q - rp_q;
  assign rdata_o = rdata_q;
  always_ff @(posedge clk)
    if (do_push) mem_q[wp_q[AW-1:0]] <= wdata_i;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
      rdata_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + 1'b1;
      if (do_pop) begin
        rp_q <= rp_q + 1'b1;
        rdata_q <= mem_q[rp_q[AW-1:0]];
      end
    end
endmodule

// File: rtl/uart_sys_cfg.sv
// uart_sys_cfg: runtime-configurable full-duplex UART with TX/RX FIFOs and sticky errors.
// Define UART_PARITY_EN to insert a parity bit (parity_odd / parity_err) into both directions.
module uart_sys_cfg
  import uart_cfg_pkg::*;
#(
  parameter int DBIT = DBIT_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DIV_W = DIV_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input logic clk,
  input logic rst_n,
  uart_cfg_if.slave bus
);
  localparam int TW = $clog2(2 * OVERSAMPLE);
  localparam int BW = $clog2(DBIT);
  localparam logic [TW-1:0] OS_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] OS_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] OS2_LAST = TW'(2 * OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DBIT - 1);
  state_t tx_state_q, rx_state_q;
  logic [DIV_W-1:0] baud_q, cnt_q;
  logic [TW-1:0] tx_tick_q, rx_tick_q;
  logic [BW-1:0] tx_bit_q, rx_bit_q;
  logic [DBIT-1:0] tx_sh_q, rx_sh_q, tx_word;
  logic [1:0] rx_sync_q;
  logic stop2_q, tx_q, frame_err_q, overrun_err_q;
  logic s_tick, tx_end, rx_end, rx_s, tx_empty, tx_pop, rx_full, rx_push;
`ifdef UART_PARITY_EN
  logic odd_q, tx_par_q, parity_err_q;
  assign bus.parity_err = parity_err_q;
`endif
  assign s_tick = cnt_q >= baud_q;
  assign tx_end = s_tick && tx_tick_q == OS_LAST;
  assign rx_end = s_tick && rx_tick_q == OS_LAST;
  assign rx_s = rx_sync_q[1];
  // Frames start on a baud tick so every bit spans exactly OVERSAMPLE ticks.
  assign tx_pop = tx_state_q == IDLE && !tx_empty && s_tick;
  assign rx_push = rx_state_q == STOP && rx_end;
  assign bus.tx = tx_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun_err = overrun_err_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      baud_q <= '0;
      stop2_q <= 1'b0;
`ifdef UART_PARITY_EN
      odd_q <= 1'b0;
`endif
      rx_sync_q <= 2'b11;
    end else begin
      cnt_q <= s_tick ? '0 : cnt_q + 1'b1;
      rx_sync_q <= {rx_sync_q[0], bus.rx};
      if (tx_state_q == IDLE && rx_state_q == IDLE) begin
        baud_q <= bus.baud_div;
        stop2_q <= bus.stop_2;
`ifdef UART_PARITY_EN
        odd_q <= bus.parity_odd;
`endif
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tx_state_q <= IDLE;
      tx_tick_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q <= '0;
      tx_q <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par_q <= 1'b0;
`endif
    end else begin
      if (s_tick && tx_state_q != IDLE) tx_tick_q <= tx_tick_q + 1'b1;
      case (tx_state_q)
        IDLE: if (tx_pop) begin
          tx_state_q <= START;
          tx_tick_q <= '0;
          tx_q <= 1'b0;
        end
        START: if (tx_end) begin
          tx_state_q <= DATA;
          tx_tick_q <= '0;
          tx_bit_q <= '0;
          tx_sh_q <= tx_word;
          tx_q <= tx_word[0];
`ifdef UART_PARITY_EN
          tx_par_q <= ^tx_word ^ odd_q;
`endif
        end
        DATA: if (tx_end) begin
          tx_tick_q <= '0;
          tx_bit_q <= tx_bit_q + 1'b1;
          tx_sh_q <= tx_sh_q >> 1;
          tx_q <= tx_sh_q[1];
          if (tx_bit_q == BIT_LAST) begin
`ifdef UART_PARITY_EN
            tx_state_q <= PARITY;
            tx_q <= tx_par_q;
`else
            tx_state_q <= STOP;
            tx_q <= 1'b1;
`endif
          end
        end
`ifdef UART_PARITY_EN
        PARITY: if (tx_end) begin
          tx_state_q <= STOP;
          tx_tick_q <= '0;
          tx_q <= 1'b1;
        end
`endif
        STOP: if (s_tick && tx_tick_q == (stop2_q ? OS2_LAST : OS_LAST)) tx_state_q <= IDLE;
        default: tx_state_q <= IDLE;
      endcase
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rx_state_q <= IDLE;
      rx_tick_q <= '0;
      rx_bit_q <= '0;
      rx_sh_q <= '0;
      frame_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
`ifdef UART_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      if (bus.err_clr) begin
        frame_err_q <= 1'b0;
        overrun_err_q <= 1'b0;
`ifdef UART_PARITY_EN
        parity_err_q <= 1'b0;
`endif
      end
      if (rx_push && rx_full) overrun_err_q <= 1'b1;
      if (s_tick && rx_state_q != IDLE) rx_tick_q <= rx_tick_q + 1'b1;
      case (rx_state_q)
        IDLE: if (!rx_s) begin
          rx_state_q <= START;
          rx_tick_q <= '0;
        end
        // A start bit that is gone by its midpoint is treated as a glitch.
        START: if (s_tick && rx_tick_q == OS_MID) begin
          rx_state_q <= rx_s ? IDLE : DATA;
          rx_tick_q <= '0;
          rx_bit_q <= '0;
        end
        DATA: if (rx_end) begin
          rx_tick_q <= '0;
          rx_bit_q <= rx_bit_q + 1'b1;
          rx_sh_q <= {rx_s, rx_sh_q[DBIT-1:1]};
`ifdef UART_PARITY_EN
          if (rx_bit_q == BIT_LAST) rx_state_q <= PARITY;
`else
          if (rx_bit_q == BIT_LAST) rx_state_q <= STOP;
`endif
        end
`ifdef UART_PARITY_EN
        PARITY: if (rx_end) begin
          rx_state_q <= STOP;
          rx_tick_q <= '0;
          if (rx_s != (^rx_sh_q ^ odd_q)) parity_err_q <= 1'b1;
        end
`endif
        STOP: if (rx_end) begin
          rx_state_q <= IDLE;
          if (!rx_s) frame_err_q <= 1'b1;
        end
        default: rx_state_q <= IDLE;
      endcase
    end
  uart_cfg_fifo #(.W(DBIT), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .push_i(bus.wr_uart), .pop_i(tx_pop), .wdata_i(bus.w_data),
    .rdata_o(tx_word), .full_o(bus.tx_full), .empty_o(tx_empty), .level_o(bus.tx_level)
  );
  uart_cfg_fifo #(.W(DBIT), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .push_i(rx_push), .pop_i(bus.rd_uart), .wdata_i(rx_sh_q),
    .rdata_o(bus.r_data), .full_o(rx_full), .empty_o(bus.rx_empty), .level_o(bus.rx_level)
  );
endmodule

// File: tb/tb_uart_sys_cfg.sv
// tb_uart_sys_cfg: scoreboard bench for uart_sys_cfg at 64 clk per bit (baud_div=3).
module tb_uart_sys_cfg;
  localparam int BITC = 64;
`ifdef UART_PARITY_EN
  localparam int NPAR = 1;
`else
  localparam int NPAR = 0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [7:0] exp_tx[$];
  logic [7:0] exp_rd[$];
  bit tx_ignore = 1'b0;
  logic [7:0] ovr_vec [17] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
                               8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h5A};
  uart_cfg_if u_if ();
  uart_sys_cfg dut (.clk(clk), .rst_n(rst_n), .bus(u_if));
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic write(input logic [7:0] d);
    u_if.w_data = d;
    u_if.wr_uart = 1'b1;
    @(negedge clk);
    u_if.wr_uart = 1'b0;
  endtask
  task automatic read();
    u_if.rd_uart = 1'b1;
    @(negedge clk);
    u_if.rd_uart = 1'b0;
  endtask
  task automatic pulse_clr();
    u_if.err_clr = 1'b1;
    @(negedge clk);
    u_if.err_clr = 1'b0;
  endtask
  task automatic send_rx(input logic [7:0] d, input logic stop_b, input logic par_flip);
    u_if.rx = 1'b0;
    clks(BITC);
    for (int i = 0; i < 8; i++) begin
      u_if.rx = d[i];
      clks(BITC);
    end
`ifdef UART_PARITY_EN
    u_if.rx = ^d ^ 1'b1 ^ par_flip;
    clks(BITC);
`endif
    u_if.rx = stop_b;
    clks(stop_b ? BITC : 48);
    u_if.rx = 1'b1;
  endtask

  // TX monitor: decodes frames on the tx pin and checks them against the TX scoreboard.
  initial begin : tx_mon
    logic [7:0] d;
    logic st, sp, p;
    bit ign;
    p = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && u_if.tx === 1'b0) begin
        ign = tx_ignore;
        clks(BITC / 2 - 1);
        st = u_if.tx;
        for (int i = 0; i < 8; i++) begin
          clks(BITC);
          d[i] = u_if.tx;
        end
`ifdef UART_PARITY_EN
        clks(BITC);
        p = u_if.tx;
`endif
        clks(BITC);
        sp = u_if.tx;
        if (!ign && !tx_ignore) begin
          if (exp_tx.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL tx_frame: got unexpected frame %0h, expected none", d);
          end else begin
            chk("tx_data", d, exp_tx.pop_front());
            chk("tx_start_bit", st, 0);
            chk("tx_stop_bit", sp, 1);
            if (NPAR != 0) chk("tx_parity_bit", p, ^d ^ 1'b1);
          end
        end
      end
    end
  end

  // Read monitor: every accepted rd_uart must present the next expected word on r_data.
  initial forever begin
    @(posedge clk);
    if (rst_n && u_if.rd_uart === 1'b1 && u_if.rx_empty === 1'b0) begin
      #1;
      if (exp_rd.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rd_data: got unexpected word %0h, expected none", u_if.r_data);
      end else chk("rd_data", u_if.r_data, exp_rd.pop_front());
    end
  end

  initial begin
    int n;
    u_if.baud_div = 11'd3;
    u_if.stop_2 = 1'b0;
    u_if.wr_uart = 1'b0;
    u_if.w_data = '0;
    u_if.rd_uart = 1'b0;
    u_if.err_clr = 1'b0;
    u_if.rx = 1'b1;
`ifdef UART_PARITY_EN
    u_if.parity_odd = 1'b1;
`endif
    clks(3);
    chk("rst_tx", u_if.tx, 1);
    chk("rst_r_data", u_if.r_data, 0);
    chk("rst_tx_full", u_if.tx_full, 0);
    chk("rst_rx_empty", u_if.rx_empty, 1);
    chk("rst_tx_level", u_if.tx_level, 0);
    chk("rst_rx_level", u_if.rx_level, 0);
    chk("rst_frame_err", u_if.frame_err, 0);
    chk("rst_overrun_err", u_if.overrun_err, 0);
    rst_n = 1'b1;
    clks(2);
    // single TX frame 0xA5
    exp_tx.push_back(8'hA5);
    write(8'hA5);
    chk("tx_level_after_wr", u_if.tx_level, 1);
    n = 0;
    while (u_if.tx !== 1'b0 && n < 20) begin n++; clks(1); end
    chk("tx_start_seen", u_if.tx, 0);
    chk("tx_level_popped", u_if.tx_level, 0);
    n = 0;
    while (u_if.tx === 1'b0 && n < 200) begin n++; clks(1); end
    chk("tx_start_low_clks", n, 64);
    clks(10 * BITC);
    // two stop bits, back-to-back frames
    u_if.stop_2 = 1'b1;
    clks(2);
    exp_tx.push_back(8'h00);
    exp_tx.push_back(8'hFF);
    write(8'h00);
    write(8'hFF);
    n = 0;
    while (u_if.tx !== 1'b0 && n < 20) begin n++; clks(1); end
    n = 0;
    while (u_if.tx === 1'b0 && n < 1000) begin n++; clks(1); end
    chk("stop2_low_clks", n, 576);
    n = 0;
    while (u_if.tx === 1'b1 && n < 1000) begin n++; clks(1); end
    chk("stop2_gap_clks", n, 132 + NPAR * BITC);
    clks(12 * BITC);
    u_if.stop_2 = 1'b0;
    // single RX frame 0x3C
    exp_rd.push_back(8'h3C);
    send_rx(8'h3C, 1'b1, 1'b0);
    chk("rx_not_empty", u_if.rx_empty, 0);
    chk("rx_level_1", u_if.rx_level, 1);
    read();
    chk("rx_empty_after_rd", u_if.rx_empty, 1);
    read();
    chk("rd_empty_holds", u_if.r_data, 8'h3C);
    // overrun: 17 frames without reading
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_rd.push_back(ovr_vec[i]);
      send_rx(ovr_vec[i], 1'b1, 1'b0);
    end
    chk("overrun_set", u_if.overrun_err, 1);
    chk("overrun_rx_level", u_if.rx_level, 16);
    chk("overrun_no_frame_err", u_if.frame_err, 0);
    pulse_clr();
    chk("overrun_cleared", u_if.overrun_err, 0);
    for (int i = 0; i < 16; i++) read();
    chk("overrun_drained", u_if.rx_empty, 1);
    // start glitch of 20 clk
    u_if.rx = 1'b0;
    clks(20);
    u_if.rx = 1'b1;
    clks(200);
    chk("glitch_no_push", u_if.rx_level, 0);
    chk("glitch_no_err", u_if.frame_err, 0);
    // stop bit held low
    exp_rd.push_back(8'h5A);
    send_rx(8'h5A, 1'b0, 1'b0);
    clks(100);
    chk("frame_err_set", u_if.frame_err, 1);
    chk("frame_err_pushed", u_if.rx_level, 1);
    read();
    pulse_clr();
    chk("frame_err_cleared", u_if.frame_err, 0);
`ifdef UART_PARITY_EN
    exp_tx.push_back(8'h01);
    write(8'h01);
    clks(12 * BITC);
    exp_rd.push_back(8'h81);
    send_rx(8'h81, 1'b1, 1'b1);
    chk("parity_err_set", u_if.parity_err, 1);
    chk("parity_err_pushed", u_if.rx_level, 1);
    read();
    pulse_clr();
    chk("parity_err_cleared", u_if.parity_err, 0);
`endif
    chk("rd_queue_drained", exp_rd.size(), 0);
    // TX FIFO fill with slowest baud so nothing drains
    tx_ignore = 1'b1;
    u_if.baud_div = 11'd2047;
    clks(2);
    for (int i = 1; i <= 17; i++) begin
      write(8'(i));
      chk("fill_tx_level", u_if.tx_level, (i > 16) ? 16 : i);
      chk("fill_tx_full", u_if.tx_full, (i >= 16) ? 1 : 0);
    end
    rst_n = 1'b0;
    u_if.baud_div = 11'd3;
    clks(2);
    chk("fill_rst_level", u_if.tx_level, 0);
    chk("fill_rst_full", u_if.tx_full, 0);
    rst_n = 1'b1;
    clks(2);
    // reset in the middle of DATA
    write(8'h00);
    write(8'h00);
    n = 0;
    while (u_if.tx !== 1'b0 && n < 20) begin n++; clks(1); end
    clks(3 * BITC);
    chk("mid_data_tx_low", u_if.tx, 0);
    chk("mid_data_level", u_if.tx_level, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx_high", u_if.tx, 1);
    chk("mid_rst_tx_level", u_if.tx_level, 0);
    chk("mid_rst_rx_level", u_if.rx_level, 0);
    @(negedge clk);
    rst_n = 1'b1;
    clks(13 * BITC);
    tx_ignore = 1'b0;
    chk("tx_queue_drained", exp_tx.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
